// File: rtl/fp_mac_sched.sv
// Two-requester scheduler for a fixed-latency FP multiply-accumulate datapath; one accumulator per requester.
// Issue is one cycle after accept, retire strobe LAT+1 cycles after issue; a requester is blocked while its op is in flight.
module fp_mac_sched #(
  parameter int LAT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [1:0]  clr,
  output logic        mac_issue,
  output logic [31:0] mac_a,
  output logic [31:0] mac_b,
  output logic [31:0] mac_c,
  input  logic [31:0] mac_res,
  output logic        res_valid,
  output logic        res_id,
  output logic [31:0] res_data,
  output logic        busy
);

  logic [31:0]    r_acc [2];
  logic [1:0]     r_inflight;
  logic           r_last;
  logic           r_mac_issue;
  logic           r_mac_id;
  logic [31:0]    r_mac_a;
  logic [31:0]    r_mac_b;
  logic [31:0]    r_mac_c;
  logic [LAT-1:0] r_sr_vld;
  logic [LAT-1:0] r_sr_id;
  logic           r_res_valid;
  logic           r_res_id;
  logic [31:0]    r_res_data;

  logic [1:0]     w_elig;
  logic [1:0]     w_grant;
  logic           w_gid;
  logic           w_due;
  logic           w_due_id;
  logic [1:0]     w_ret;

  always_comb begin
    w_elig     = req_valid & ~r_inflight & ~clr;
    // On a tie, r_last names the requester served most recently, so the other one wins.
    w_grant[0] = w_elig[0] & (~w_elig[1] | r_last);
    w_grant[1] = w_elig[1] & (~w_elig[0] | ~r_last);
    w_gid      = w_grant[1];
    w_due      = r_sr_vld[LAT-1];
    w_due_id   = r_sr_id[LAT-1];
    w_ret      = {w_due & w_due_id, w_due & ~w_due_id};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) r_acc[i] <= '0;
      r_inflight  <= '0;
      r_last      <= 1'b1;
      r_mac_issue <= 1'b0;
      r_mac_id    <= 1'b0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_mac_c     <= '0;
      r_sr_vld    <= '0;
      r_sr_id     <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_mac_issue <= |w_grant;
      if (|w_grant) begin
        r_mac_id <= w_gid;
        r_mac_a  <= w_gid ? req_a[63:32] : req_a[31:0];
        r_mac_b  <= w_gid ? req_b[63:32] : req_b[31:0];
        r_mac_c  <= r_acc[w_gid];
        r_last   <= w_gid;
      end
      // Stage 0 loads from the issue register, so the tail lines up with the result cycle.
      r_sr_vld    <= {r_sr_vld[LAT-2:0], r_mac_issue};
      r_sr_id     <= {r_sr_id[LAT-2:0], r_mac_id};
      r_inflight  <= (r_inflight & ~w_ret) | w_grant;
      r_res_valid <= w_due;
      if (w_due) begin
        r_res_id   <= w_due_id;
        r_res_data <= mac_res;
      end
      for (int i = 0; i < 2; i++) begin
        if (clr[i])        r_acc[i] <= '0;
        else if (w_ret[i]) r_acc[i] <= mac_res;
      end
    end
  end

  assign req_ready = w_grant;
  assign mac_issue = r_mac_issue;
  assign mac_a     = r_mac_a;
  assign mac_b     = r_mac_b;
  assign mac_c     = r_mac_c;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_data  = r_res_data;
  assign busy      = |r_inflight;

endmodule

// File: doc/fp_mac_sched.md
FP_MAC_SCHED -- requirements
Module: fp_mac_sched

Interface
REQ-001 SHALL have parameter LAT, default 8, meaning fixed MAC datapath latency in cycles from the mac_issue cycle to the mac_res valid cycle; legal range 2..32.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  2  operation request per requester; bit i is requester i.
REQ-005 SHALL have port req_ready  output  2  grant per requester, combinational; transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-006 SHALL have port req_a  input  64  multiplicand, IEEE-754 single; requester i in bits [32i+31:32i].
REQ-007 SHALL have port req_b  input  64  multiplier, same packing as req_a.
REQ-008 SHALL have port clr  input  2  per-requester accumulator clear.
REQ-009 SHALL have port mac_issue  output  1  registered; datapath operation valid.
REQ-010 SHALL have ports mac_a, mac_b, mac_c  output  32 each  registered operands to the datapath; datapath computes a*b+c.
REQ-011 SHALL have port mac_res  input  32  datapath result, valid exactly LAT cycles after the corresponding mac_issue cycle.
REQ-012 SHALL have ports res_valid  output  1, res_id  output  1, res_data  output  32  registered retire strobe, owning requester and result.
REQ-013 SHALL have port busy  output  1  high while any operation is in flight.

Function
REQ-014 SHALL hold one 32-bit accumulator acc[i] and one inflight[i] flag per requester.
REQ-015 SHALL define eligible[i] = req_valid[i] & ~inflight[i] & ~clr[i].
REQ-016 SHALL grant at most one requester per cycle; when only one is eligible, that one is granted; when both are eligible, the one not granted most recently is granted.
REQ-017 SHALL drive req_ready[i] = grant[i]; req_ready[i] is never high while req_valid[i] is low.
REQ-018 SHALL, at an accepting edge for requester i, set inflight[i] and update the last-granted pointer, and in the next cycle drive mac_issue=1, mac_a/mac_b = requester i operands, and mac_c = acc[i]; mac_issue SHALL be 0 in every other cycle.
REQ-019 SHALL carry valid and id through a LAT-deep shift register aligned so that the entry issued in cycle k is at the output in cycle k+LAT.
REQ-020 SHALL, at the end of cycle k+LAT, write mac_res to acc[id] and clear inflight[id], then in cycle k+LAT+1 drive res_valid=1, res_id=id, res_data=that mac_res value.
REQ-021 SHALL ignore mac_res in every cycle in which no tracked entry is due.
REQ-022 SHALL yield a minimum same-requester accept-to-accept spacing of LAT+2 cycles, so no accumulation hazard reaches the datapath.
REQ-023 SHALL allow the two requesters to interleave, with at most two operations in flight.
REQ-024 SHALL, when clr[i] is high at an edge, set acc[i] to 0; if a result for i retires on the same edge, clear wins for acc[i], and res_valid/res_data SHALL still report the result.
REQ-025 SHALL hold res_data and res_id between strobes; res_valid SHALL be a one-cycle pulse per retirement.
REQ-026 SHALL drive busy = |inflight.

Reset
REQ-027 SHALL, with reset high at an edge, set acc, inflight, the shift register, mac_issue, mac_a, mac_b, mac_c, res_valid, res_id and res_data to 0, and set the last-granted pointer to requester 1 so that requester 0 wins the first tie.
REQ-028 SHALL, on reset during operation, discard in-flight operations; no res_valid SHALL follow for them, and late mac_res values SHALL be ignored.

Verification (LAT=8, bench datapath model returns a*b+c)
REQ-029 SHALL pass: reset, then req0 a=3F800000 b=40000000 accepted in cycle 0 -> mac_issue in cycle 1 with mac_c=00000000; res_valid in cycle 10 with id 0 and data 40000000; acc0=40000000.
REQ-030 SHALL pass: req0 held valid continuously with a=3F800000 b=40000000 -> accepts in cycles 0, 10 and 20; second mac_c=40000000; third result=40C00000.
REQ-031 SHALL pass: both requesters valid in cycle 0 after reset -> req_ready=01 in cycle 0 and 10 in cycle 1; mac_issue in cycles 1 and 2; results retire with id 0 in cycle 10 and id 1 in cycle 11.
REQ-032 SHALL pass: clr[0]=1 on the retirement edge of a req0 operation -> res_data shows the result, acc0=0, and the next req0 issue has mac_c=00000000.
REQ-033 SHALL pass: clr[1]=1 together with req_valid[1]=1 -> req_ready[1]=0 that cycle; grant occurs the following cycle.
REQ-034 SHALL pass: reset asserted 4 cycles after an issue -> busy=0 after the reset edge; res_valid stays 0 for at least 20 cycles while mac_res is driven with FFFFFFFF.
